// File: rtl/uart_xmit_of_verifla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_xmit_of_verifla_pkg
//  Brief    : State encoding and counter widths for the VeriFLA UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_xmit_of_verifla_pkg;

    localparam int c_state_w    = 3;
    localparam int c_bit_cnt_w  = 3;
    localparam int c_stop_cnt_w = 1;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } xmit_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_xmit_of_verifla_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_xmit_of_verifla_if
//  Brief    : Request/done handshake and serial line between sender and UART.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_xmit_of_verifla_if;

    logic       xmitH;
    logic [7:0] xmit_dataH;
    logic       xmit_doneH;
    logic       xmit_busyH;
    logic       txd;

    modport master (
        output xmitH,
        output xmit_dataH,
        input  xmit_doneH,
        input  xmit_busyH,
        input  txd
    );

    modport slave (
        input  xmitH,
        input  xmit_dataH,
        output xmit_doneH,
        output xmit_busyH,
        output txd
    );

endinterface
`default_nettype wire

// File: rtl/uart_xmit_of_verifla.sv
`default_nettype none
// ============================================================================
//  Module   : uart_xmit_of_verifla
//  Brief    : Baud-tick paced 8-bit async serial transmitter with done handshake.
//             Optional parity bit when VERIFLA_UART_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_xmit_of_verifla
    import uart_xmit_of_verifla_pkg::*;
#(
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               baud_clk_posedge,
    uart_xmit_of_verifla_if.slave   xif
);

    localparam logic [c_bit_cnt_w-1:0]  c_last_bit  = 3'd7;
    localparam logic [c_stop_cnt_w-1:0] c_stop_last = c_stop_cnt_w'(STOP_BITS - 1);

    // The stop counter is only wide enough for one or two stop periods.
    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_xmit_of_verifla: STOP_BITS must be 1..2 and PARITY_ODD 0..1");
    end

    xmit_state_t             r_state;
    logic [7:0]              r_shift;
    logic [c_bit_cnt_w-1:0]  r_bit_cnt;
    logic [c_stop_cnt_w-1:0] r_stop_cnt;
    logic                    r_txd;
    logic                    r_done;
    logic                    r_busy;

`ifdef VERIFLA_UART_PARITY_EN
    localparam logic c_parity_odd = (PARITY_ODD != 0);
    logic            r_parity;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_txd      <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef VERIFLA_UART_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (baud_clk_posedge) begin
            case (r_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (xif.xmitH) begin
                        r_shift <= xif.xmit_dataH;
`ifdef VERIFLA_UART_PARITY_EN
                        // Taken from the accepted octet; the shifter is consumed later.
                        r_parity <= (^xif.xmit_dataH) ^ c_parity_odd;
`endif
                        r_busy  <= 1'b1;
                        r_txd   <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_txd     <= r_shift[0];
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_cnt <= '0;
                    r_state   <= ST_DATA;
                end
                ST_DATA: begin
                    if (r_bit_cnt == c_last_bit) begin
                        r_bit_cnt <= '0;
`ifdef VERIFLA_UART_PARITY_EN
                        r_txd   <= r_parity;
                        r_state <= ST_PARITY;
`else
                        r_txd      <= 1'b1;
                        r_stop_cnt <= '0;
                        r_state    <= ST_STOP;
`endif
                    end else begin
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
`ifdef VERIFLA_UART_PARITY_EN
                ST_PARITY: begin
                    r_txd      <= 1'b1;
                    r_stop_cnt <= '0;
                    r_state    <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    r_txd <= 1'b1;
                    if (r_stop_cnt == c_stop_last) begin
                        r_stop_cnt <= '0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_stop_cnt <= r_stop_cnt + c_stop_cnt_w'(1);
                    end
                end
                ST_DONE: begin
                    r_txd   <= 1'b1;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_txd      <= 1'b1;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_bit_cnt  <= '0;
                    r_stop_cnt <= '0;
                end
            endcase
        end
    end

    assign xif.txd        = r_txd;
    assign xif.xmit_doneH = r_done;
    assign xif.xmit_busyH = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_xmit_of_verifla.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_xmit_of_verifla
//  Brief    : Directed self-checking bench for uart_xmit_of_verifla.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_xmit_of_verifla;

`ifdef VERIFLA_UART_PARITY_EN
    localparam int c_p = 1;
`else
    localparam int c_p = 0;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       baud    = 1'b0;
    logic       baud_en = 1'b1;
    logic [2:0] req     = 3'b000;
    logic [7:0] dat [3] = '{default: 8'h00};
    logic [2:0] txd_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    int vectors     = 0;
    int miscompares = 0;

    // dut0: 1 stop, even; dut1: 2 stops, even; dut2: 1 stop, odd
    uart_xmit_of_verifla_if xif0 ();
    uart_xmit_of_verifla_if xif1 ();
    uart_xmit_of_verifla_if xif2 ();

    assign xif0.xmitH = req[0];  assign xif0.xmit_dataH = dat[0];
    assign xif1.xmitH = req[1];  assign xif1.xmit_dataH = dat[1];
    assign xif2.xmitH = req[2];  assign xif2.xmit_dataH = dat[2];
    assign txd_w[0] = xif0.txd;  assign busy_w[0] = xif0.xmit_busyH;  assign done_w[0] = xif0.xmit_doneH;
    assign txd_w[1] = xif1.txd;  assign busy_w[1] = xif1.xmit_busyH;  assign done_w[1] = xif1.xmit_doneH;
    assign txd_w[2] = xif2.txd;  assign busy_w[2] = xif2.xmit_busyH;  assign done_w[2] = xif2.xmit_doneH;

    uart_xmit_of_verifla #(.STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst(rst), .baud_clk_posedge(baud), .xif(xif0.slave));
    uart_xmit_of_verifla #(.STOP_BITS(2), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .baud_clk_posedge(baud), .xif(xif1.slave));
    uart_xmit_of_verifla #(.STOP_BITS(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst(rst), .baud_clk_posedge(baud), .xif(xif2.slave));

    always #5 clk = ~clk;

    // One-clock baud enable every fourth clock, updated on the falling edge.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            baud = baud_en && (cnt == 3);
            cnt  = (cnt + 1) % 4;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Advance to just after the next baud tick edge.
    task automatic tick();
        int n;
        n = 0;
        @(posedge clk);
        while (!baud && n < 64) begin
            @(posedge clk);
            n++;
        end
        if (!baud) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout: baud=%b after 64 clocks, required 1", baud);
        end
        #1;
    endtask

    // order[7] is the first data bit on the line; par is the hand-computed parity bit.
    task automatic frame(input int d, input logic [7:0] data, input logic [7:0] order,
                         input logic par, input int stops, input bit inject, input string name);
        int   nper;
        logic exp_txd;
        nper = 1 + 8 + c_p + stops;
        req[d] = 1'b1;
        dat[d] = data;
        tick();
        req[d] = 1'b0;
        for (int i = 0; i < nper; i++) begin
            if (i == 0)                   exp_txd = 1'b0;
            else if (i <= 8)              exp_txd = order[8 - i];
            else if (c_p == 1 && i == 9)  exp_txd = par;
            else                          exp_txd = 1'b1;
            vectors++;
            if (txd_w[d] !== exp_txd || busy_w[d] !== 1'b1 || done_w[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_period%0d: txd=%b busy=%b done=%b, required txd=%b busy=1 done=0",
                         name, i + 1, txd_w[d], busy_w[d], done_w[d], exp_txd);
            end
            if (inject && i == 3) begin
                req[d] = 1'b1;
                dat[d] = 8'h55;
            end
            if (inject && i == 5) req[d] = 1'b0;
            tick();
        end
        vectors++;
        if (txd_w[d] !== 1'b1 || busy_w[d] !== 1'b1 || done_w[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done: txd=%b busy=%b done=%b, required txd=1 busy=1 done=1",
                     name, txd_w[d], busy_w[d], done_w[d]);
        end
        tick();
        vectors++;
        if (txd_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: txd=%b busy=%b done=%b, required txd=1 busy=0 done=0",
                     name, txd_w[d], busy_w[d], done_w[d]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (txd_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_dut%0d: txd=%b busy=%b done=%b, required txd=1 busy=0 done=0",
                         d, txd_w[d], busy_w[d], done_w[d]);
            end
        end
        rst = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (txd_w[d] !== 1'b1 || busy_w[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_dut%0d: txd=%b busy=%b, required txd=1 busy=0", d, txd_w[d], busy_w[d]);
            end
        end
    endtask

    task automatic test_frame_a5();
        frame(0, 8'hA5, 8'b10100101, 1'b0, 1, 1'b0, "a5");
    endtask

    task automatic test_stop2();
        frame(1, 8'hFF, 8'b11111111, 1'b0, 2, 1'b0, "stop2_ff");
    endtask

    task automatic test_ignore_busy_request();
        frame(0, 8'h3C, 8'b00111100, 1'b0, 1, 1'b1, "ignore_55");
        tick();
        vectors++;
        if (busy_w[0] !== 1'b0 || txd_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_no_requeue: busy=%b txd=%b, required busy=0 txd=1", busy_w[0], txd_w[0]);
        end
    endtask

    task automatic test_back_to_back();
        frame(0, 8'h12, 8'b01001000, 1'b0, 1, 1'b0, "b2b_12");
        frame(0, 8'h34, 8'b00101100, 1'b1, 1, 1'b0, "b2b_34");
    endtask

`ifdef VERIFLA_UART_PARITY_EN
    task automatic test_parity();
        frame(0, 8'h07, 8'b11100000, 1'b1, 1, 1'b0, "par_even_07");
        frame(0, 8'h03, 8'b11000000, 1'b0, 1, 1'b0, "par_even_03");
        frame(2, 8'h03, 8'b11000000, 1'b1, 1, 1'b0, "par_odd_03");
    endtask
`endif

    task automatic test_freeze();
        bit moved;
        req[0] = 1'b1;
        dat[0] = 8'hA5;
        tick();
        req[0] = 1'b0;
        tick();
        baud_en = 1'b0;
        moved = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b1 || done_w[0] !== 1'b0) moved = 1'b1;
        end
        vectors++;
        if (moved) begin
            miscompares++;
            $display("FAIL freeze_hold: outputs changed without baud tick, required static txd=1 busy=1");
        end
        baud_en = 1'b1;
        tick();
        vectors++;
        if (txd_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL freeze_resume: txd=%b, required 0 (bit1 of 0xA5)", txd_w[0]);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_data();
        bit saw_done;
        req[0] = 1'b1;
        dat[0] = 8'hA5;
        tick();
        req[0] = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_data: txd=%b busy=%b done=%b, required txd=1 busy=0 done=0",
                     txd_w[0], busy_w[0], done_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (15) begin
            tick();
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || txd_w[0] !== 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL reset_abandon: activity after reset, required txd=1 busy=0 done=0 throughout");
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_stop2();
        test_ignore_busy_request();
        test_back_to_back();
`ifdef VERIFLA_UART_PARITY_EN
        test_parity();
`endif
        test_freeze();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_xmit_of_verifla.md
Name: uart_xmit_of_verifla

Overview:
- Serial transmitter directly downstream of the capture-send state machine.
- Accepts one octet per `xmitH` request, serialises it as an asynchronous frame on `txd`, and returns `xmit_doneH`.
- All bit timing and handshake sampling is paced by the shared `baud_clk_posedge` enable, so the upstream sender (which updates only on that enable) sees each request exactly once and each done exactly once.

Parameters:
- `STOP_BITS`, 1, number of stop-bit periods (legal: 1 or 2).
- `PARITY_ODD`, 0, parity sense when the parity feature is compiled in (0 = even, 1 = odd); ignored otherwise.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset.
- `baud_clk_posedge`  input  1  one-`clk`-wide enable; one pulse = one bit period.
- `xmitH`  input  1  transmit request, level held by the sender for a whole baud period.
- `xmit_dataH`  input  8  octet to send; valid while `xmitH`=1.
- `xmit_doneH`  output  1  frame complete; held high for exactly one baud period.
- `xmit_busyH`  output  1  high from frame accept until `xmit_doneH` falls.
- `txd`  output  1  serial line; idle high.

Interface:
- One clock, `clk`; reset `rst` is asynchronous, active-high.
- All outputs are registered. State only advances on a `clk` edge where `baud_clk_posedge`=1 (a "tick").

Behaviour:
- Reset (asserted at any time, including mid-frame): `txd`=1, `xmit_doneH`=0, `xmit_busyH`=0. State goes to IDLE, shift register and bit counter clear. The partial frame is abandoned; no `xmit_doneH` is issued for it.
- States: IDLE, START, DATA, PARITY (feature only), STOP, DONE.
- IDLE: `txd`=1.
  - On a tick with `xmitH`=1: latch `xmit_dataH` into the shift register, set `xmit_busyH`=1, drive `txd`=0, go to START.
  - `xmitH` between ticks is not sampled.
- START: `txd`=0 for one tick period. On the next tick, drive `txd`=bit0, go to DATA with bit counter=0.
- DATA: LSB first. Each tick shifts the register right and increments the counter.
  - After bit7's period, go to PARITY (feature) or STOP, driving `txd` accordingly (parity bit or 1).
  - The 3-bit counter wraps from 7 only by the state exit; no other wrap is legal.
- STOP: `txd`=1 for `STOP_BITS` tick periods (stop counter). On the final tick, go to DONE and set `xmit_doneH`=1.
- DONE: `txd`=1, `xmit_doneH`=1 for exactly one tick period. On the next tick: `xmit_doneH`=0, `xmit_busyH`=0, go to IDLE.
- `xmitH` seen on a tick in any state other than IDLE (including DONE) is ignored. The octet is not queued. No other side effect.
- Frame length in ticks from accept to `xmit_doneH` rise: 1 + 8 + P + `STOP_BITS`, where P=1 with parity and 0 without. `xmit_doneH` then lasts 1 tick.
- Back-to-back operation with the upstream sender:
  - The sender samples done at the DONE→IDLE tick and raises `xmitH` for the following period.
  - The next frame starts at the following tick, so one idle-high bit period separates frames.
- `baud_clk_posedge` held low: all state frozen, outputs static.
- Illegal state encoding: recover to IDLE on the next tick with `txd`=1.

Optional Feature:
- Macro: `VERIFLA_UART_PARITY_EN`.
- Defined: a PARITY state follows DATA for one tick period.
  - `txd` = XOR of the 8 data bits, XOR `PARITY_ODD`.
  - Parity is computed from the octet latched at accept, not from the shifted register.
- Undefined: no PARITY state, no parity logic; DATA goes straight to STOP; `PARITY_ODD` is unused.

Decomposition:
- Shared package/config include holds the state encoding constants (width 3) and the stop-bit counter width.
- No sub-module. Parity is a single reduction XOR inline. The baud enable comes from the existing shared tick generator, not from this block.

Test Plan:
- Reset mid-DATA (after 3 ticks into 0xA5): assert `rst` → `txd`=1, `xmit_busyH`=0, `xmit_doneH`=0 immediately; no `xmit_doneH` afterwards.
- Send 0xA5, `STOP_BITS`=1, no parity → `txd` per tick: 0,1,0,1,0,0,1,0,1,1. `xmit_doneH` high on tick 11's period only. `xmit_busyH` high for 11 tick periods.
- Parity enabled, `PARITY_ODD`=0, send 0x07 → parity bit 1; send 0x03 → parity bit 0. With `PARITY_ODD`=1, send 0x03 → parity bit 1.
- `STOP_BITS`=2, send 0xFF → 2 stop periods high; `xmit_doneH` rises 11 ticks after accept.
- `xmitH`=1 with 0x55 during DATA of 0x3C → 0x3C frame unchanged; 0x55 never transmitted.
- Model the upstream sender sending 2 octets 0x12, 0x34 back-to-back → two clean frames, one idle bit between them, two `xmit_doneH` pulses each one tick period wide.
